mem_readout_arb: RTL and testbench
==================================

Name: mem_readout_arb

Overview:
- Reads out one event's worth of data from 12 buffer memories, one item per clock, and merges it into a single tagged output stream.
- On each new event it loads the item count of every memory. A 12-input priority encoder then drains the memories in index order, lowest index first.
- For each item it drives that memory's read address. When the data returns from the synchronous RAMs, it emits a 52-bit word: BX tag, memory index, data.
- Sits between the per-sector stub memories and the downstream link serializer.

Parameters:
- NUM_MEM, 12, number of source memories (fixed 12; ports are enumerated 00..11).
- DATA_W, 45, memory data width.
- CNT_W, 6, item-count and address width.
- READ_LAT, 2, clocks from addrNN change to the matching mem_datNN (external address register plus registered RAM).
- MAX_CLKS, 7'd100, no new reads are issued once clk_cnt >= MAX_CLKS (per-BX time budget).

Ports:
- clk  in  1  main clock, all logic on rising edge.
- reset  in  1  synchronous, active-high reset.
- new_event  in  1  start readout of a new event; samples items00..11 and BX.
- BX  in  3  bunch-crossing number of the event being started.
- clk_cnt  in  7  clocks elapsed in current BX.
- BX_pipe  in  3  pipeline BX counter; informational, not used in datapath.
- items00..items11  in  6 each  item count per memory, valid while new_event=1.
- mem_dat00..mem_dat11  in  45 each  read data per memory, READ_LAT after address.
- addr00..addr11  out  6 each  read address per memory.
- mem_dat_stream  out  52  {bx_tag[2:0], mem_idx[3:0], data[44:0]}.
- valid  out  1  mem_dat_stream carries a real item this cycle.
- none  out  1  no items remain to be issued for the current event.

Behaviour:
- Reset:
  - all remaining counts = 0, all addrNN = 0, bx_tag = 0.
  - valid = 0, mem_dat_stream = 0, none = 1.
  - pipeline valid bits cleared.
- new_event=1 (takes priority over everything except reset):
  - remaining[i] <= itemsNN; rd_ptr[i] <= 0; bx_tag <= BX.
  - All in-flight pipeline entries are flushed (their valid cleared).
  - Nothing is issued on the new_event cycle itself.
- Issue, each cycle with new_event=0:
  - req[i] = (remaining[i] != 0).
  - The priority encoder selects the lowest i with req[i]=1.
  - If any request exists and clk_cnt < MAX_CLKS: rd_ptr[sel]++ and remaining[sel]--. Push {sel, 1} into a READ_LAT-deep pipeline; otherwise push {x, 0}.
- Addresses:
  - addrNN = rd_ptr[NN], registered and combinationally visible.
  - The address of the item being issued is the pre-increment pointer, presented the cycle it is issued.
  - Addresses count 0,1,..,items-1 per memory.
  - Unselected memories hold their address.
- Output:
  - When a pipeline entry emerges with valid, mem_dat_stream <= {bx_tag, idx, mem_dat[idx]} registered, and valid <= 1.
  - Total latency from issue to valid = READ_LAT+1 clocks.
  - If no valid entry emerges: valid <= 0 and mem_dat_stream holds its last value.
- none = 1 when all remaining = 0 (combinational from counts). Pipeline may still be draining while none = 1.
- Boundaries:
  - items = 0 for a memory: that memory is never selected.
  - items = 63: 63 reads from that memory, addresses 0..62; no wrap.
  - All items zero: none stays 1, no valid.
  - new_event mid-readout: unread items are abandoned and the pipeline is flushed.
  - Budget expiry (clk_cnt >= MAX_CLKS): issue stops and counts freeze until the next new_event.
- mem_idx is 4 bits, values 0..11.

Optional Feature:
- Macro: MEM_READOUT_HEADER_EN.
- Defined: on the cycle after new_event, emit one header word with valid=1.
  - mem_dat_stream = {BX[2:0], 4'hF, 3'b0, 42'b0 with items counts summed into bits [11:0]}.
  - Data items follow, each delayed by one extra clock.
- Undefined: no header; mem_idx value 4'hF never appears.

Decomposition:
- Package mem_readout_pkg: NUM_MEM, DATA_W, CNT_W, STREAM_W = 52, MAX_CLKS, header index constant 4'hF, and typedef for the stream word struct {bx, idx, data}.
- One sub-module: prio_enc12, a 12-bit request vector in, 4-bit index plus any-valid out, lowest index wins.

Test Plan:
- Reset asserted 3 cycles -> valid = 0, none = 1, all addrNN = 0.
- new_event with items00=0, items01=1, items02=3, rest 0, BX=5 -> reads issue in this order: addr01 = 0, then addr02 = 0, 1, 2. Four valid words appear READ_LAT+1 later, idx sequence 1, 2, 2, 2, bx_tag = 5. none = 1 after the 4th issue.
- All items = 0 -> none stays 1, valid never asserts.
- items00=24, items10=24 -> 48 consecutive valid cycles, idx 0 ×24 then 10 ×24, addresses 0..23 each.
- new_event reasserted after 5 issues of items02=24 -> pipeline flushed, no stale words, counts reloaded from new items, bx_tag = BX+1.
- clk_cnt forced to 100 mid-readout -> issue stops, counts hold, in-flight words still emerge, none stays 0.

Source files
------------

// File: rtl/mem_readout_pkg.sv
// Shared constants and the output word layout for the memory readout arbiter.
// Latency: n/a (type and constant definitions only).
// Backpressure: n/a.
package mem_readout_pkg;

    localparam int NUM_MEM  = 12;
    localparam int DATA_W   = 45;
    localparam int CNT_W    = 6;
    localparam int IDX_W    = 4;
    localparam int BX_W     = 3;
    localparam int READ_LAT = 2;
    localparam int STREAM_W = 52;

    // Per-BX time budget; no new reads are issued once clk_cnt reaches this.
    localparam logic [6:0] MAX_CLKS = 7'd100;

    // Memory index reserved for the optional event header word.
    localparam logic [IDX_W-1:0] HDR_IDX = 4'hF;

    typedef struct packed {
        logic [BX_W-1:0]   bx;
        logic [IDX_W-1:0]  idx;
        logic [DATA_W-1:0] data;
    } stream_t;

endpackage

// File: rtl/prio_enc12.sv
// 12-input priority encoder: lowest asserted request wins.
// Latency: purely combinational.
// Backpressure: none; output follows the request vector.
//   req     : request vector, bit i = memory i has work
//   idx     : index of the lowest asserted request (0 when none)
//   any_vld : at least one request is asserted
module prio_enc12 (
    input  logic [11:0] req,
    output logic [3:0]  idx,
    output logic        any_vld
);

    // Scan from the top down so the lowest set bit is the last one written.
    always_comb begin
        idx = 4'd0;
        for (int i = 11; i >= 0; i--) begin
            if (req[i]) begin
                idx = 4'(i);
            end
        end
    end

    assign any_vld = |req;

endmodule

// File: rtl/mem_readout_arb.sv
// Drains one event from 12 buffer memories in index order into one tagged stream.
// Latency: READ_LAT+1 clocks from issuing an address to the matching valid word.
// Backpressure: none downstream; issue is throttled only by the per-BX clk_cnt budget.
//   clk, reset              : clock, synchronous active-high reset
//   new_event, BX, items00..11 : start an event, its BX tag and per-memory item counts
//   clk_cnt                 : clocks elapsed in the current BX (issue budget)
//   BX_pipe                 : pipeline BX counter, informational only
//   mem_dat00..11 / addr00..11 : synchronous RAM read data / read addresses
//   mem_dat_stream, valid   : {bx_tag, mem_idx, data} output word and its qualifier
//   none                    : no items left to issue for the current event
// Optional build macro MEM_READOUT_HEADER_EN: emit a header word (idx 4'hF, summed
// item counts) the cycle after new_event; data words then arrive one clock later.
module mem_readout_arb
    import mem_readout_pkg::*;
(
    input  logic                clk,
    input  logic                reset,
    input  logic                new_event,
    input  logic [2:0]          BX,
    input  logic [6:0]          clk_cnt,
    input  logic [2:0]          BX_pipe,
    input  logic [CNT_W-1:0]    items00, items01, items02, items03,
    input  logic [CNT_W-1:0]    items04, items05, items06, items07,
    input  logic [CNT_W-1:0]    items08, items09, items10, items11,
    input  logic [DATA_W-1:0]   mem_dat00, mem_dat01, mem_dat02, mem_dat03,
    input  logic [DATA_W-1:0]   mem_dat04, mem_dat05, mem_dat06, mem_dat07,
    input  logic [DATA_W-1:0]   mem_dat08, mem_dat09, mem_dat10, mem_dat11,
    output logic [CNT_W-1:0]    addr00, addr01, addr02, addr03,
    output logic [CNT_W-1:0]    addr04, addr05, addr06, addr07,
    output logic [CNT_W-1:0]    addr08, addr09, addr10, addr11,
    output logic [STREAM_W-1:0] mem_dat_stream,
    output logic                valid,
    output logic                none
);

    logic [CNT_W-1:0]  items_a   [NUM_MEM];
    logic [DATA_W-1:0] mem_dat_a [NUM_MEM];

    assign items_a = '{items00, items01, items02, items03, items04, items05,
                       items06, items07, items08, items09, items10, items11};
    assign mem_dat_a = '{mem_dat00, mem_dat01, mem_dat02, mem_dat03, mem_dat04, mem_dat05,
                         mem_dat06, mem_dat07, mem_dat08, mem_dat09, mem_dat10, mem_dat11};

    // BX_pipe is carried on the port for the system's benefit only.
    logic unused_bx_pipe;
    assign unused_bx_pipe = ^BX_pipe;

    logic [CNT_W-1:0] remaining_q [NUM_MEM];
    logic [CNT_W-1:0] remaining_d [NUM_MEM];
    logic [CNT_W-1:0] rd_ptr_q    [NUM_MEM];
    logic [CNT_W-1:0] rd_ptr_d    [NUM_MEM];
    logic [BX_W-1:0]  bx_tag_q, bx_tag_d;
    logic [READ_LAT-1:0] pipe_vld_q, pipe_vld_d;
    logic [IDX_W-1:0] pipe_idx_q  [READ_LAT];
    logic [IDX_W-1:0] pipe_idx_d  [READ_LAT];
    stream_t          stream_q, stream_d;
    logic             valid_q, valid_d;

    logic [NUM_MEM-1:0] req;
    logic [IDX_W-1:0]   sel_idx;
    logic               sel_vld;
    logic               issue;
    logic               emerge_vld;
    stream_t            emerge_word;

    always_comb begin
        for (int i = 0; i < NUM_MEM; i++) begin
            req[i] = (remaining_q[i] != '0);
        end
    end

    prio_enc12 u_prio_enc12 (
        .req     (req),
        .idx     (sel_idx),
        .any_vld (sel_vld)
    );

    assign issue = sel_vld && (clk_cnt < MAX_CLKS) && !new_event;

    // The entry leaving the last pipeline stage lines up with its RAM data.
    always_comb begin
        emerge_vld       = pipe_vld_q[READ_LAT-1];
        emerge_word.bx   = bx_tag_q;
        emerge_word.idx  = pipe_idx_q[READ_LAT-1];
        emerge_word.data = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (pipe_idx_q[READ_LAT-1] == IDX_W'(i)) begin
                emerge_word.data = mem_dat_a[i];
            end
        end
    end

`ifdef MEM_READOUT_HEADER_EN
    stream_t     dly_dat_q, dly_dat_d;
    logic        dly_vld_q, dly_vld_d;
    logic [11:0] hdr_sum;

    always_comb begin
        hdr_sum = '0;
        for (int i = 0; i < NUM_MEM; i++) begin
            hdr_sum = hdr_sum + 12'(items_a[i]);
        end
    end
`endif

    always_comb begin
        remaining_d = remaining_q;
        rd_ptr_d    = rd_ptr_q;
        bx_tag_d    = bx_tag_q;
        pipe_vld_d  = {pipe_vld_q[READ_LAT-2:0], issue};
        pipe_idx_d[0] = sel_idx;
        for (int k = 1; k < READ_LAT; k++) begin
            pipe_idx_d[k] = pipe_idx_q[k-1];
        end
        stream_d = stream_q;
        valid_d  = 1'b0;

        if (issue) begin
            for (int i = 0; i < NUM_MEM; i++) begin
                if (sel_idx == IDX_W'(i)) begin
                    rd_ptr_d[i]    = rd_ptr_q[i] + CNT_W'(1);
                    remaining_d[i] = remaining_q[i] - CNT_W'(1);
                end
            end
        end

`ifdef MEM_READOUT_HEADER_EN
        // Extra stage makes room for the header in front of the data words.
        dly_vld_d = emerge_vld;
        dly_dat_d = emerge_word;
        if (dly_vld_q) begin
            stream_d = dly_dat_q;
            valid_d  = 1'b1;
        end
`else
        if (emerge_vld) begin
            stream_d = emerge_word;
            valid_d  = 1'b1;
        end
`endif

        // A new event abandons the old one, including words already in flight.
        if (new_event) begin
            for (int i = 0; i < NUM_MEM; i++) begin
                remaining_d[i] = items_a[i];
                rd_ptr_d[i]    = '0;
            end
            bx_tag_d   = BX;
            pipe_vld_d = '0;
            stream_d   = stream_q;
            valid_d    = 1'b0;
`ifdef MEM_READOUT_HEADER_EN
            dly_vld_d = 1'b0;
            stream_d  = stream_t'{bx: BX, idx: HDR_IDX, data: DATA_W'(hdr_sum)};
            valid_d   = 1'b1;
`endif
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < NUM_MEM; i++) begin
                remaining_q[i] <= '0;
                rd_ptr_q[i]    <= '0;
            end
            for (int k = 0; k < READ_LAT; k++) begin
                pipe_idx_q[k] <= '0;
            end
            bx_tag_q   <= '0;
            pipe_vld_q <= '0;
            stream_q   <= '0;
            valid_q    <= 1'b0;
`ifdef MEM_READOUT_HEADER_EN
            dly_vld_q  <= 1'b0;
            dly_dat_q  <= '0;
`endif
        end else begin
            remaining_q <= remaining_d;
            rd_ptr_q    <= rd_ptr_d;
            pipe_idx_q  <= pipe_idx_d;
            bx_tag_q    <= bx_tag_d;
            pipe_vld_q  <= pipe_vld_d;
            stream_q    <= stream_d;
            valid_q     <= valid_d;
`ifdef MEM_READOUT_HEADER_EN
            dly_vld_q   <= dly_vld_d;
            dly_dat_q   <= dly_dat_d;
`endif
        end
    end

    assign {addr00, addr01, addr02, addr03, addr04, addr05} =
           {rd_ptr_q[0], rd_ptr_q[1], rd_ptr_q[2], rd_ptr_q[3], rd_ptr_q[4], rd_ptr_q[5]};
    assign {addr06, addr07, addr08, addr09, addr10, addr11} =
           {rd_ptr_q[6], rd_ptr_q[7], rd_ptr_q[8], rd_ptr_q[9], rd_ptr_q[10], rd_ptr_q[11]};

    assign mem_dat_stream = stream_q;
    assign valid          = valid_q;

    always_comb begin
        none = 1'b1;
        for (int i = 0; i < NUM_MEM; i++) begin
            if (remaining_q[i] != '0) begin
                none = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mem_readout_arb.sv
// Self-checking bench for mem_readout_arb with a two-stage synchronous RAM model.
// Latency: n/a.
// Backpressure: n/a.
module tb_mem_readout_arb;

    logic        clk = 1'b0;
    logic        reset, new_event;
    logic [2:0]  BX, BX_pipe;
    logic [6:0]  clk_cnt;
    logic [5:0]  items [12];
    logic [44:0] mdat  [12];
    logic [5:0]  addr  [12];
    logic [5:0]  areg  [12];
    logic [51:0] stream;
    logic        valid, none;

    int errors = 0;
    int checks = 0;
    logic [20:0] salt = 21'h0;

    logic [51:0] got_w[$];
    int          got_k[$];
    logic        got_none[$];
    logic [51:0] exp_q[$];

    always #5 clk = ~clk;

    mem_readout_arb dut (
        .clk(clk), .reset(reset), .new_event(new_event), .BX(BX),
        .clk_cnt(clk_cnt), .BX_pipe(BX_pipe),
        .items00(items[0]), .items01(items[1]), .items02(items[2]), .items03(items[3]),
        .items04(items[4]), .items05(items[5]), .items06(items[6]), .items07(items[7]),
        .items08(items[8]), .items09(items[9]), .items10(items[10]), .items11(items[11]),
        .mem_dat00(mdat[0]), .mem_dat01(mdat[1]), .mem_dat02(mdat[2]), .mem_dat03(mdat[3]),
        .mem_dat04(mdat[4]), .mem_dat05(mdat[5]), .mem_dat06(mdat[6]), .mem_dat07(mdat[7]),
        .mem_dat08(mdat[8]), .mem_dat09(mdat[9]), .mem_dat10(mdat[10]), .mem_dat11(mdat[11]),
        .addr00(addr[0]), .addr01(addr[1]), .addr02(addr[2]), .addr03(addr[3]),
        .addr04(addr[4]), .addr05(addr[5]), .addr06(addr[6]), .addr07(addr[7]),
        .addr08(addr[8]), .addr09(addr[9]), .addr10(addr[10]), .addr11(addr[11]),
        .mem_dat_stream(stream), .valid(valid), .none(none)
    );

    // Contents of memory i at address a.
    function automatic logic [44:0] ram_val(input int i, input int a);
        logic [13:0] mix;
        mix = 14'(a * 37 + i * 5);
        return {salt, 4'(i), 6'(a), mix};
    endfunction

    // External address register followed by a registered RAM: two clocks.
    always @(posedge clk) begin
        for (int i = 0; i < 12; i++) begin
            areg[i] <= addr[i];
            mdat[i] <= ram_val(i, int'(areg[i]));
        end
    end

    // Spec order: memory 0 first, each memory's items at addresses 0..n-1.
    task automatic add_exp(input logic [2:0] bx);
        for (int i = 0; i < 12; i++)
            for (int a = 0; a < int'(items[i]); a++)
                exp_q.push_back({bx, 4'(i), ram_val(i, a)});
    endtask

    task automatic clear_items();
        for (int i = 0; i < 12; i++) items[i] = 6'd0;
    endtask

    // Called at a negedge; returns at the negedge of the first cycle after new_event.
    task automatic start_event(input logic [2:0] bx);
        new_event = 1'b1;
        BX = bx;
        @(negedge clk);
        new_event = 1'b0;
    endtask

    task automatic collect(input int n);
        got_w.delete(); got_k.delete(); got_none.delete();
        for (int k = 0; k < n; k++) begin
            got_none.push_back(none);
            if (valid) begin
                got_w.push_back(stream);
                got_k.push_back(k);
            end
            @(negedge clk);
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; new_event = 1'b0; BX = 3'd0; BX_pipe = 3'd0; clk_cnt = 7'd0;
        clear_items();
        repeat (3) @(negedge clk);
        checks++;
        if (valid !== 1'b0) begin errors++; $display("FAIL reset_valid got=%b exp=0", valid); end
        checks++;
        if (none !== 1'b1) begin errors++; $display("FAIL reset_none got=%b exp=1", none); end
        checks++;
        if (stream !== 52'd0) begin errors++; $display("FAIL reset_stream got=%h exp=0", stream); end
        for (int i = 0; i < 12; i++) begin
            checks++;
            if (addr[i] !== 6'd0) begin errors++; $display("FAIL reset_addr%0d got=%0d exp=0", i, addr[i]); end
        end
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_directed();
        salt = 21'($urandom);
        clear_items(); items[1] = 6'd1; items[2] = 6'd3;
        exp_q.delete(); add_exp(3'd5);
        start_event(3'd5);
        collect(16);
        checks++;
        if (got_w.size() != 4) begin errors++; $display("FAIL dir_count got=%0d exp=4", got_w.size()); end
        for (int j = 0; j < got_w.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_w[j] !== exp_q[j]) begin errors++; $display("FAIL dir_word%0d got=%h exp=%h", j, got_w[j], exp_q[j]); end
            checks++;
            if (got_k[j] != 3 + j) begin errors++; $display("FAIL dir_latency%0d got=%0d exp=%0d", j, got_k[j], 3 + j); end
        end
        checks++;
        if (got_none[3] !== 1'b0 || got_none[4] !== 1'b1) begin
            errors++; $display("FAIL dir_none got=%b%b exp=01", got_none[3], got_none[4]);
        end
        checks++;
        if (addr[1] !== 6'd1 || addr[2] !== 6'd3) begin
            errors++; $display("FAIL dir_addr got=%0d,%0d exp=1,3", addr[1], addr[2]);
        end
    endtask

    task automatic test_all_zero();
        int bad;
        clear_items();
        start_event(3'($urandom));
        collect(20);
        bad = 0;
        foreach (got_none[k]) if (got_none[k] !== 1'b1) bad++;
        checks++;
        if (bad != 0) begin errors++; $display("FAIL zero_none got=%0d cycles low exp=0", bad); end
        checks++;
        if (got_w.size() != 0) begin errors++; $display("FAIL zero_valid got=%0d words exp=0", got_w.size()); end
    endtask

    task automatic test_back_to_back();
        logic [2:0] bx;
        bx = 3'($urandom); salt = 21'($urandom);
        clear_items(); items[0] = 6'd24; items[10] = 6'd24;
        exp_q.delete(); add_exp(bx);
        start_event(bx);
        collect(60);
        checks++;
        if (got_w.size() != 48) begin errors++; $display("FAIL b2b_count got=%0d exp=48", got_w.size()); end
        else begin
            checks++;
            if (got_k[0] != 3 || got_k[47] != 50) begin
                errors++; $display("FAIL b2b_span got=%0d..%0d exp=3..50", got_k[0], got_k[47]);
            end
        end
        for (int j = 0; j < got_w.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_w[j] !== exp_q[j]) begin errors++; $display("FAIL b2b_word%0d got=%h exp=%h", j, got_w[j], exp_q[j]); end
        end
        checks++;
        if (addr[0] !== 6'd24 || addr[10] !== 6'd24) begin
            errors++; $display("FAIL b2b_addr got=%0d,%0d exp=24,24", addr[0], addr[10]);
        end
    endtask

    task automatic test_max_items();
        logic [2:0] bx;
        bx = 3'($urandom); salt = 21'($urandom);
        clear_items(); items[5] = 6'd63;
        exp_q.delete(); add_exp(bx);
        start_event(bx);
        collect(75);
        checks++;
        if (got_w.size() != 63) begin errors++; $display("FAIL max_count got=%0d exp=63", got_w.size()); end
        for (int j = 0; j < got_w.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_w[j] !== exp_q[j]) begin errors++; $display("FAIL max_word%0d got=%h exp=%h", j, got_w[j], exp_q[j]); end
        end
        checks++;
        if (addr[5] !== 6'd63 || none !== 1'b1) begin
            errors++; $display("FAIL max_end got=addr %0d none %b exp=addr 63 none 1", addr[5], none);
        end
    endtask

    task automatic test_random();
        logic [2:0] bx;
        for (int it = 0; it < 5; it++) begin
            bx = 3'($urandom); salt = 21'($urandom);
            for (int i = 0; i < 12; i++)
                items[i] = ($urandom_range(0, 2) == 0) ? 6'd0 : 6'($urandom_range(1, 6));
            exp_q.delete(); add_exp(bx);
            start_event(bx);
            collect(exp_q.size() + 10);
            checks++;
            if (got_w.size() != exp_q.size()) begin
                errors++; $display("FAIL rnd%0d_count got=%0d exp=%0d", it, got_w.size(), exp_q.size());
            end
            for (int j = 0; j < got_w.size() && j < exp_q.size(); j++) begin
                checks++;
                if (got_w[j] !== exp_q[j]) begin errors++; $display("FAIL rnd%0d_word%0d got=%h exp=%h", it, j, got_w[j], exp_q[j]); end
            end
            if (got_w.size() > 0) begin
                checks++;
                if (got_k[0] != 3 || got_k[got_k.size()-1] - got_k[0] + 1 != got_w.size()) begin
                    errors++; $display("FAIL rnd%0d_timing got=first %0d last %0d exp=first 3 contiguous", it, got_k[0], got_k[got_k.size()-1]);
                end
            end
            checks++;
            if (none !== 1'b1) begin errors++; $display("FAIL rnd%0d_none got=%b exp=1", it, none); end
        end
    endtask

    task automatic test_mid_event();
        logic [2:0] b;
        b = 3'($urandom); salt = 21'($urandom);
        clear_items(); items[2] = 6'd24;
        start_event(b);
        // Issues at k=0..4; those from k=3,4 are still in flight at the restart.
        exp_q.delete();
        for (int a = 0; a < 3; a++) exp_q.push_back({b, 4'd2, ram_val(2, a)});
        exp_q.push_back({3'(b + 3'd1), 4'd3, ram_val(3, 0)});
        exp_q.push_back({3'(b + 3'd1), 4'd3, ram_val(3, 1)});
        exp_q.push_back({3'(b + 3'd1), 4'd7, ram_val(7, 0)});
        got_w.delete(); got_k.delete();
        for (int k = 0; k < 30; k++) begin
            if (k == 5) begin
                new_event = 1'b1; BX = 3'(b + 3'd1);
                clear_items(); items[3] = 6'd2; items[7] = 6'd1;
            end else begin
                new_event = 1'b0;
            end
            if (valid) begin got_w.push_back(stream); got_k.push_back(k); end
            @(negedge clk);
        end
        checks++;
        if (got_w.size() != 6) begin errors++; $display("FAIL mid_count got=%0d exp=6", got_w.size()); end
        for (int j = 0; j < got_w.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_w[j] !== exp_q[j]) begin errors++; $display("FAIL mid_word%0d got=%h exp=%h", j, got_w[j], exp_q[j]); end
        end
        if (got_k.size() > 3) begin
            checks++;
            if (got_k[3] != 9) begin errors++; $display("FAIL mid_restart_latency got=%0d exp=9", got_k[3]); end
        end
        checks++;
        if (addr[2] !== 6'd0 || addr[3] !== 6'd2) begin
            errors++; $display("FAIL mid_addr got=%0d,%0d exp=0,2", addr[2], addr[3]);
        end
    endtask

    task automatic test_budget();
        logic [2:0] bx;
        int low;
        bx = 3'($urandom); salt = 21'($urandom);
        clear_items(); items[4] = 6'd20;
        exp_q.delete();
        for (int a = 0; a < 6; a++) exp_q.push_back({bx, 4'd4, ram_val(4, a)});
        start_event(bx);
        got_w.delete(); low = 0;
        for (int k = 0; k < 30; k++) begin
            if (k == 6) clk_cnt = 7'd100;
            if (none !== 1'b0) low++;
            if (valid) got_w.push_back(stream);
            @(negedge clk);
        end
        checks++;
        if (got_w.size() != 6) begin errors++; $display("FAIL budget_count got=%0d exp=6", got_w.size()); end
        for (int j = 0; j < got_w.size() && j < exp_q.size(); j++) begin
            checks++;
            if (got_w[j] !== exp_q[j]) begin errors++; $display("FAIL budget_word%0d got=%h exp=%h", j, got_w[j], exp_q[j]); end
        end
        checks++;
        if (low != 0) begin errors++; $display("FAIL budget_none got=%0d cycles high exp=0", low); end
        checks++;
        if (addr[4] !== 6'd6) begin errors++; $display("FAIL budget_addr got=%0d exp=6", addr[4]); end
        clk_cnt = 7'd0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_all_zero();
        test_back_to_back();
        test_max_items();
        test_random();
        test_mid_event();
        test_budget();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
